key_event_decoder: RTL and testbench

Consumer side of the key debouncer interface. Takes the debouncer's one-cycle `KEY_FLAG` pulse and `KEY_STATE` level and classifies each press as short, long, or auto-repeat. Hold time is measured in `TICK` enables from the shared clock divider, so the block needs no wide private prescaler. It sits between each debounced key and the clock-setting control logic.

---
 rtl/key_event_pkg.sv | 30 +++
 rtl/key_tick_timer.sv | 34 +++
 rtl/key_event_decoder.sv | 158 +++++++++++++++
 tb/tb_key_event_decoder.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// key_event_pkg
//   Shared definitions for the key event decoder slice.
//   - key_state_t : one-hot decoder states (GAP/SWALLOW only reachable when
//                   KEY_EVENT_DOUBLE_PRESS_EN is defined)
//   - DEF_*_TICKS : default tick counts for a 1 kHz TICK
//   - max3        : largest of three counts, used to size the tick counters
package key_event_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_PRESSED   = 5'b00010,
    ST_LONG_HELD = 5'b00100,
    ST_GAP       = 5'b01000,
    ST_SWALLOW   = 5'b10000
  } key_state_t;

  // 1 kHz TICK: 1 s long press, 200 ms repeat, 250 ms double-press window
  localparam int unsigned DEF_LONG_TICKS   = 1000;
  localparam int unsigned DEF_REPEAT_TICKS = 200;
  localparam int unsigned DEF_DOUBLE_TICKS = 250;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_tick_timer.sv
// key_tick_timer
//   Saturating tick counter with synchronous clear and terminal-count compare.
//   Ports:
//     CLK, nRST : clock, asynchronous active-low reset
//     CLR       : clear count to 0 (has priority over TICK)
//     TICK      : count enable, +1 per cycle high
//     AT_TERM   : count currently equals TERM-1 (the next TICK is terminal)
module key_tick_timer #(
  parameter int unsigned W    = 11,
  parameter int unsigned TERM = 1
) (
  input  logic CLK,
  input  logic nRST,
  input  logic CLR,
  input  logic TICK,
  output logic AT_TERM
);

  localparam logic [W-1:0] TERM_M1 = W'(TERM - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt <= '0;
    else if (CLR)
      cnt <= '0;
    else if (TICK && (cnt != '1))
      cnt <= cnt + W'(1);
  end

  assign AT_TERM = (cnt == TERM_M1);

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies debounced key presses as short, long or auto-repeat, timing
//   the hold in TICK enables from the shared divider.
//   Optional feature macro: KEY_EVENT_DOUBLE_PRESS_EN (double-press detect;
//   SHORT_PRESS is then deferred until the double-press window expires).
//   Ports:
//     CLK, nRST    : clock, asynchronous active-low reset
//     TICK         : one-cycle divider enable
//     KEY_FLAG     : debouncer edge pulse
//     KEY_STATE    : debounced level (0 = pressed)
//     SHORT_PRESS  : pulse, press released before LONG_TICKS
//     LONG_PRESS   : pulse, LONG_TICKS ticks of hold reached
//     REPEAT       : pulse, every REPEAT_TICKS ticks after LONG_PRESS
//     DOUBLE_PRESS : pulse, second press within DOUBLE_TICKS (0 without macro)
//     HELD         : level, key held (PRESSED or LONG_HELD)
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS,
  parameter int unsigned DOUBLE_TICKS = DEF_DOUBLE_TICKS
) (
  input  logic CLK,
  input  logic nRST,
  input  logic TICK,
  input  logic KEY_FLAG,
  input  logic KEY_STATE,
  output logic SHORT_PRESS,
  output logic LONG_PRESS,
  output logic REPEAT,
  output logic DOUBLE_PRESS,
  output logic HELD
);

  localparam int unsigned CNT_W =
    $clog2(max3(LONG_TICKS, REPEAT_TICKS, DOUBLE_TICKS)) + 1;

  key_state_t state, state_nxt;

  logic press, rel;
  logic hold_term, rep_term;
  logic short_nxt, long_nxt, rep_nxt, dbl_nxt, held_nxt;

  assign press = KEY_FLAG & ~KEY_STATE;
  assign rel   = KEY_FLAG &  KEY_STATE;

  // Each timer is held clear whenever the FSM is outside the state that uses
  // it, so every state entry starts from 0 and the press cycle's own TICK is
  // never counted.
  key_tick_timer #(.W(CNT_W), .TERM(LONG_TICKS)) u_hold (
    .CLK     (CLK),
    .nRST    (nRST),
    .CLR     (state != ST_PRESSED),
    .TICK    (TICK),
    .AT_TERM (hold_term)
  );

  key_tick_timer #(.W(CNT_W), .TERM(REPEAT_TICKS)) u_rep (
    .CLK     (CLK),
    .nRST    (nRST),
    .CLR     ((state != ST_LONG_HELD) || (TICK && rep_term)),
    .TICK    (TICK),
    .AT_TERM (rep_term)
  );

`ifdef KEY_EVENT_DOUBLE_PRESS_EN
  logic gap_term;

  key_tick_timer #(.W(CNT_W), .TERM(DOUBLE_TICKS)) u_gap (
    .CLK     (CLK),
    .nRST    (nRST),
    .CLR     (state != ST_GAP),
    .TICK    (TICK),
    .AT_TERM (gap_term)
  );
`endif

  // Next state and next outputs; outputs are registered below so each pulse
  // appears the cycle after its cause. Release/press take priority over a
  // coincident terminal TICK.
  always_comb begin
    state_nxt = state;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    rep_nxt   = 1'b0;
    dbl_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (press)
          state_nxt = ST_PRESSED;
      end
      ST_PRESSED: begin
        if (rel) begin
`ifdef KEY_EVENT_DOUBLE_PRESS_EN
          state_nxt = ST_GAP;
`else
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
`endif
        end else if (TICK && hold_term) begin
          long_nxt  = 1'b1;
          state_nxt = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (rel)
          state_nxt = ST_IDLE;
        else if (TICK && rep_term)
          rep_nxt = 1'b1;
      end
`ifdef KEY_EVENT_DOUBLE_PRESS_EN
      ST_GAP: begin
        if (press) begin
          dbl_nxt   = 1'b1;
          state_nxt = ST_SWALLOW;
        end else if (TICK && gap_term) begin
          short_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_SWALLOW: begin
        if (rel)
          state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    held_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG_HELD);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      SHORT_PRESS <= 1'b0;
      LONG_PRESS  <= 1'b0;
      REPEAT      <= 1'b0;
      HELD        <= 1'b0;
    end else begin
      state       <= state_nxt;
      SHORT_PRESS <= short_nxt;
      LONG_PRESS  <= long_nxt;
      REPEAT      <= rep_nxt;
      HELD        <= held_nxt;
    end
  end

`ifdef KEY_EVENT_DOUBLE_PRESS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      DOUBLE_PRESS <= 1'b0;
    else
      DOUBLE_PRESS <= dbl_nxt;
  end
`else
  assign DOUBLE_PRESS = dbl_nxt;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
//   Self-checking bench for key_event_decoder (LONG=4, REPEAT=2, DOUBLE=3).
//   Build with KEY_EVENT_DOUBLE_PRESS_EN to exercise the double-press option.
module tb_key_event_decoder;

  localparam int unsigned LONG_T   = 4;
  localparam int unsigned REPEAT_T = 2;
  localparam int unsigned DOUBLE_T = 3;

  logic CLK = 1'b0;
  logic nRST, TICK, KEY_FLAG, KEY_STATE;
  logic SHORT_PRESS, LONG_PRESS, REPEAT, DOUBLE_PRESS, HELD;

  always #5 CLK = ~CLK;

  key_event_decoder #(
    .LONG_TICKS   (LONG_T),
    .REPEAT_TICKS (REPEAT_T),
    .DOUBLE_TICKS (DOUBLE_T)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .TICK         (TICK),
    .KEY_FLAG     (KEY_FLAG),
    .KEY_STATE    (KEY_STATE),
    .SHORT_PRESS  (SHORT_PRESS),
    .LONG_PRESS   (LONG_PRESS),
    .REPEAT       (REPEAT),
    .DOUBLE_PRESS (DOUBLE_PRESS),
    .HELD         (HELD)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: tracks how many ticks the key has been down and how many
  // ticks have elapsed since a release, and derives events arithmetically.
  int  m_mode;        // 0 up, 1 down, 2 waiting for second press, 3 ignoring until release
  int  m_down_ticks;
  int  m_gap_ticks;
  logic e_short, e_long, e_rep, e_dbl, e_held;

  task automatic model_reset();
    m_mode = 0; m_down_ticks = 0; m_gap_ticks = 0;
    e_short = 0; e_long = 0; e_rep = 0; e_dbl = 0; e_held = 0;
  endtask

  task automatic model_step(input logic t, input logic f, input logic s);
    logic pr, rl;
    pr = f & ~s;
    rl = f & s;
    e_short = 0; e_long = 0; e_rep = 0; e_dbl = 0;
    case (m_mode)
      0: if (pr) begin m_mode = 1; m_down_ticks = 0; end
      1: begin
        if (rl) begin
          if (m_down_ticks < int'(LONG_T)) begin
`ifdef KEY_EVENT_DOUBLE_PRESS_EN
            m_mode = 2; m_gap_ticks = 0;
`else
            e_short = 1; m_mode = 0;
`endif
          end else
            m_mode = 0;
        end else if (t) begin
          m_down_ticks++;
          if (m_down_ticks == int'(LONG_T))
            e_long = 1;
          else if (m_down_ticks > int'(LONG_T) &&
                   ((m_down_ticks - int'(LONG_T)) % int'(REPEAT_T)) == 0)
            e_rep = 1;
        end
      end
      2: begin
        if (pr) begin e_dbl = 1; m_mode = 3; end
        else if (t) begin
          m_gap_ticks++;
          if (m_gap_ticks == int'(DOUBLE_T)) begin e_short = 1; m_mode = 0; end
        end
      end
      default: if (rl) m_mode = 0;
    endcase
    e_held = (m_mode == 1);
  endtask

  int unsigned phase = 0;
  int unsigned cyc_no = 0;
  bit rnd_tick = 0;
  int unsigned c_short, c_long, c_rep, c_dbl, c_held;

  task automatic clr_counts();
    c_short = 0; c_long = 0; c_rep = 0; c_dbl = 0; c_held = 0;
  endtask

  // One clock: drive inputs, let the DUT sample them, then compare.
  task automatic cyc(input logic f, input logic s);
    int unsigned n_ev;
    TICK = rnd_tick ? ($urandom_range(0, 2) == 0) : (phase == 3);
    phase = (phase + 1) % 4;
    KEY_FLAG = f;
    KEY_STATE = s;
    @(posedge CLK);
    model_step(TICK, f, s);
    cyc_no++;
    #1;
    check("short",  SHORT_PRESS,  e_short);
    check("long",   LONG_PRESS,   e_long);
    check("repeat", REPEAT,       e_rep);
    check("double", DOUBLE_PRESS, e_dbl);
    check("held",   HELD,         e_held);
    n_ev = SHORT_PRESS + LONG_PRESS + REPEAT + DOUBLE_PRESS;
    check("one_event", n_ev <= 1, 1);
    c_short += SHORT_PRESS; c_long += LONG_PRESS; c_rep += REPEAT;
    c_dbl += DOUBLE_PRESS;  c_held += HELD;
  endtask

  // Key held at level s with no flags until n TICKs have been applied.
  task automatic hold_ticks(input int unsigned n, input logic s);
    int unsigned seen = 0;
    while (seen < n) begin
      if (phase == 3) seen++;
      cyc(1'b0, s);
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  int unsigned t_press;

  initial begin
    nRST = 1'b0; TICK = 0; KEY_FLAG = 0; KEY_STATE = 1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("rst_short", SHORT_PRESS, 0);
    check("rst_long",  LONG_PRESS, 0);
    check("rst_rep",   REPEAT, 0);
    check("rst_dbl",   DOUBLE_PRESS, 0);
    check("rst_held",  HELD, 0);
    nRST = 1'b1;
    idle(4);

    // Short press: 2 ticks then release.
    clr_counts();
    cyc(1'b1, 1'b0); t_press = cyc_no;
    hold_ticks(2, 1'b0);
    cyc(1'b1, 1'b1);
    check("short_held_span", c_held, cyc_no - t_press);
    idle(20);
    check("short_count", c_short, 1);
    check("short_nolong", c_long, 0);

    // Long press with repeats: 9 ticks held.
    clr_counts();
    cyc(1'b1, 1'b0);
    hold_ticks(9, 1'b0);
    cyc(1'b1, 1'b1);
    idle(20);
    check("lr_long", c_long, 1);
    check("lr_rep", c_rep, 2);
    check("lr_short", c_short, 0);

    // Release coincident with the 4th tick.
    clr_counts();
    cyc(1'b1, 1'b0);
    hold_ticks(3, 1'b0);
    while (phase != 3) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    idle(20);
    check("sim_short", c_short, 1);
    check("sim_long", c_long, 0);

    // Reset mid-hold.
    clr_counts();
    cyc(1'b1, 1'b0);
    hold_ticks(3, 1'b0);
    nRST = 1'b0;
    #1;
    check("mid_rst_held", HELD, 0);
    check("mid_rst_long", LONG_PRESS, 0);
    model_reset();
    KEY_FLAG = 0;
    @(posedge CLK); @(posedge CLK);
    phase = (phase + 2) % 4;
    #1;
    nRST = 1'b1;
    hold_ticks(6, 1'b0);
    cyc(1'b1, 1'b1);
    idle(8);
    check("mid_rst_events", c_short + c_long + c_rep + c_dbl, 0);

    // Spurious flags: release in idle, extra press while pressed.
    clr_counts();
    cyc(1'b1, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0);
    hold_ticks(1, 1'b0);
    cyc(1'b1, 1'b0);
    hold_ticks(3, 1'b0);
    check("spur_long_at_4th", LONG_PRESS, 1);
    cyc(1'b1, 1'b1);
    idle(20);
    check("spur_long_count", c_long, 1);
    check("spur_short", c_short, 0);

`ifdef KEY_EVENT_DOUBLE_PRESS_EN
    // Double press within the window.
    clr_counts();
    cyc(1'b1, 1'b0);
    hold_ticks(1, 1'b0);
    cyc(1'b1, 1'b1);
    hold_ticks(1, 1'b1);
    cyc(1'b1, 1'b0);
    hold_ticks(2, 1'b0);
    cyc(1'b1, 1'b1);
    idle(20);
    check("dbl_count", c_dbl, 1);
    check("dbl_short", c_short, 0);

    // Single press: SHORT_PRESS after the 3rd gap tick.
    clr_counts();
    cyc(1'b1, 1'b0);
    hold_ticks(1, 1'b0);
    cyc(1'b1, 1'b1);
    hold_ticks(2, 1'b1);
    check("gap_early", c_short, 0);
    hold_ticks(1, 1'b1);
    check("gap_short_at_3rd", SHORT_PRESS, 1);
    idle(8);
`endif

    // Randomized phase: sparse flags, mostly consistent levels, random ticks.
    rnd_tick = 1;
    begin
      logic lvl = 1'b1;
      for (int unsigned i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 19) == 0) begin
          if ($urandom_range(0, 4) != 0) lvl = ~lvl;
          else lvl = 1'($urandom_range(0, 1));
          cyc(1'b1, lvl);
        end else
          cyc(1'b0, lvl);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
